// File: rtl/vga_cursor_controller_pkg.sv
// Shared constants, FSM encoding and wrap-around step helper for the cursor controller.
package vga_cursor_controller_pkg;

    localparam int unsigned NUM_BLOCKS_X = 10;
    localparam int unsigned NUM_BLOCKS_Y = 8;
    localparam int unsigned BLOCK_SIZE   = 64;
    localparam int unsigned POS_W        = 4;
    localparam int unsigned NUM_BTNS     = 5;

    // Button indices: directions first, centre last
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_CENTER = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } cursor_pos_t;

    // One step along an axis; opposing requests cancel, wrap via explicit limit compare
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                  input logic             dec,
                                                  input logic             inc,
                                                  input int unsigned      limit);
        logic [POS_W-1:0] res;
        res = pos;
        if (dec && !inc) begin
            res = (pos == POS_W'(0)) ? POS_W'(limit - 1) : pos - POS_W'(1);
        end else if (inc && !dec) begin
            res = (pos == POS_W'(limit - 1)) ? POS_W'(0) : pos + POS_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_cursor_controller_if.sv
// Button/vsync inputs and committed cursor outputs of the cursor controller.
interface vga_cursor_controller_if import vga_cursor_controller_pkg::*; ();

    logic             iBtnUp;
    logic             iBtnDown;
    logic             iBtnLeft;
    logic             iBtnRight;
    logic             iBtnCenter;
    logic             iVGAVerticalSync;
    logic [POS_W-1:0] oMarkedBlockPosX;
    logic [POS_W-1:0] oMarkedBlockPosY;
    logic             oMoveStrobe;

    modport master (
        output iBtnUp, iBtnDown, iBtnLeft, iBtnRight, iBtnCenter, iVGAVerticalSync,
        input  oMarkedBlockPosX, oMarkedBlockPosY, oMoveStrobe
    );

    modport slave (
        input  iBtnUp, iBtnDown, iBtnLeft, iBtnRight, iBtnCenter, iVGAVerticalSync,
        output oMarkedBlockPosX, oMarkedBlockPosY, oMoveStrobe
    );

endinterface

// File: rtl/vga_cursor_button.sv
// One button: 2-flop synchronizer, debouncer and frame-based auto-repeat FSM.
// req_o pulses for one cycle per accepted press and per auto-repeat.
module vga_cursor_button import vga_cursor_controller_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES     = 500000,
    parameter int unsigned DB_CNT_WIDTH        = 20,
    parameter int unsigned REPEAT_DELAY_FRAMES = 30,
    parameter int unsigned REPEAT_RATE_FRAMES  = 6,
    parameter int unsigned FR_CNT_WIDTH        = 6,
    parameter int unsigned REPEAT_EN           = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic btn_i,
    input  logic frame_tick_i,
    output logic req_o
);

    logic                    sync1_q, sync2_q;
    logic                    db_q, db_d;
    logic [DB_CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic                    db_rise_c;
    btn_state_e              state_q, state_d;
    logic [FR_CNT_WIDTH-1:0] fr_cnt_q, fr_cnt_d;
    logic [FR_CNT_WIDTH-1:0] fr_inc_c;
    logic                    delay_done_c, rate_done_c;
    logic                    req_q, req_d;

    // Synchronizer and debounce registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_CNT_WIDTH'(1);
            end
        end
    end

    assign db_rise_c    = db_d & ~db_q;
    assign fr_inc_c     = fr_cnt_q + FR_CNT_WIDTH'(1);
    assign delay_done_c = frame_tick_i && (fr_inc_c == FR_CNT_WIDTH'(REPEAT_DELAY_FRAMES));
    assign rate_done_c  = frame_tick_i && (fr_inc_c == FR_CNT_WIDTH'(REPEAT_RATE_FRAMES));

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            fr_cnt_q <= '0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fr_cnt_q <= fr_cnt_d;
            req_q    <= req_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d  = state_q;
        fr_cnt_d = fr_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (db_rise_c && (REPEAT_EN != 0)) begin
                    state_d  = ST_DELAY;
                    fr_cnt_d = '0;
                end
            end
            ST_DELAY: begin
                if (delay_done_c) begin
                    state_d  = ST_REPEAT;
                    fr_cnt_d = '0;
                end else if (frame_tick_i) begin
                    fr_cnt_d = fr_inc_c;
                end
            end
            ST_REPEAT: begin
                if (rate_done_c) begin
                    fr_cnt_d = '0;
                end else if (frame_tick_i) begin
                    fr_cnt_d = fr_inc_c;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                fr_cnt_d = '0;
            end
        endcase
        // Releasing the button abandons any repeat in progress
        if ((state_q != ST_IDLE) && !db_q) begin
            state_d  = ST_IDLE;
            fr_cnt_d = '0;
        end
    end

    // FSM output
    always_comb begin
        req_d = 1'b0;
        unique case (state_q)
            ST_IDLE:   req_d = db_rise_c;
            ST_DELAY:  req_d = db_q && delay_done_c;
            ST_REPEAT: req_d = db_q && rate_done_c;
            default:   req_d = 1'b0;
        endcase
    end

    assign req_o = req_q;

endmodule

// File: rtl/vga_cursor_controller.sv
// Cursor position sequencer: collects button requests and commits one step per axis
// at each vsync falling edge so the marked block never changes mid-frame.
module vga_cursor_controller import vga_cursor_controller_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES     = 500000,
    parameter int unsigned DB_CNT_WIDTH        = 20,
    parameter int unsigned REPEAT_DELAY_FRAMES = 30,
    parameter int unsigned REPEAT_RATE_FRAMES  = 6,
    parameter int unsigned FR_CNT_WIDTH        = 6
) (
    input  logic                    Clock,
    input  logic                    Reset,
    vga_cursor_controller_if.slave  bus
);

    logic                vs1_q, vs2_q, vs_prev_q;
    logic                frame_tick_c;
    logic [NUM_BTNS-1:0] btn_raw_c;
    logic [NUM_BTNS-1:0] req_c;
    logic [NUM_BTNS-1:0] pend_q, pend_d;
    cursor_pos_t         pos_q, pos_d;
    logic                strobe_q;

    // vsync idles high, so its synchronizer resets to 1 to avoid a spurious tick
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vs1_q     <= 1'b1;
            vs2_q     <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            vs1_q     <= bus.iVGAVerticalSync;
            vs2_q     <= vs1_q;
            vs_prev_q <= vs2_q;
        end
    end

    assign frame_tick_c = vs_prev_q & ~vs2_q;

    assign btn_raw_c = {bus.iBtnCenter, bus.iBtnRight, bus.iBtnLeft, bus.iBtnDown, bus.iBtnUp};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        vga_cursor_button #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .DB_CNT_WIDTH        (DB_CNT_WIDTH),
            .REPEAT_DELAY_FRAMES (REPEAT_DELAY_FRAMES),
            .REPEAT_RATE_FRAMES  (REPEAT_RATE_FRAMES),
            .FR_CNT_WIDTH        (FR_CNT_WIDTH),
            .REPEAT_EN           ((i == BTN_CENTER) ? 0 : 1)
        ) u_btn (
            .Clock        (Clock),
            .Reset        (Reset),
            .btn_i        (btn_raw_c[i]),
            .frame_tick_i (frame_tick_c),
            .req_o        (req_c[i])
        );
    end

    // Requests arriving in the tick cycle survive into the next frame
    assign pend_d = frame_tick_c ? req_c : (pend_q | req_c);

    always_comb begin
        pos_d = pos_q;
        if (pend_q[BTN_CENTER]) begin
            pos_d.x = POS_W'(NUM_BLOCKS_X / 2);
            pos_d.y = POS_W'(NUM_BLOCKS_Y / 2);
        end else begin
            pos_d.x = step_pos(pos_q.x, pend_q[BTN_LEFT], pend_q[BTN_RIGHT], NUM_BLOCKS_X);
            pos_d.y = step_pos(pos_q.y, pend_q[BTN_UP], pend_q[BTN_DOWN], NUM_BLOCKS_Y);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend_q   <= '0;
            pos_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            strobe_q <= frame_tick_c && (pos_d != pos_q);
            if (frame_tick_c) begin
                pos_q <= pos_d;
            end
        end
    end

    assign bus.oMarkedBlockPosX = pos_q.x;
    assign bus.oMarkedBlockPosY = pos_q.y;
    assign bus.oMoveStrobe      = strobe_q;

endmodule

// File: tb/tb_vga_cursor_controller.sv
// Frame-level bench for vga_cursor_controller: directed scenarios plus random button
// activity, checked against a per-frame behavioural model of pending/repeat/commit.
module tb_vga_cursor_controller;
    import vga_cursor_controller_pkg::*;

    localparam int FRAME_LEN = 64;
    localparam int DLY       = 3;
    localparam int RATE      = 2;
    localparam int NX        = 10;
    localparam int NY        = 8;

    logic Clock;
    logic Reset;
    vga_cursor_controller_if bus ();

    vga_cursor_controller #(
        .DEBOUNCE_CYCLES     (4),
        .DB_CNT_WIDTH        (20),
        .REPEAT_DELAY_FRAMES (DLY),
        .REPEAT_RATE_FRAMES  (RATE),
        .FR_CNT_WIDTH        (6)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int vectors;
    int miscompares;

    // Model: bit order up, down, left, right, centre
    bit m_held [5];
    int m_ticks[5];
    bit m_pend [5];
    int m_x, m_y;

    function automatic void model_reset();
        m_x = 0;
        m_y = 0;
        for (int i = 0; i < 5; i++) begin
            m_held[i]  = 1'b0;
            m_ticks[i] = 0;
            m_pend[i]  = 1'b0;
        end
    endfunction

    function automatic void model_set_levels(input logic [4:0] l);
        for (int i = 0; i < 5; i++) begin
            if (l[i] && !m_held[i]) begin
                m_pend[i]  = 1'b1;
                m_ticks[i] = 0;
            end
            if (!l[i]) m_ticks[i] = 0;
            m_held[i] = l[i];
        end
    endfunction

    function automatic bit model_tick();
        int nx, ny;
        bit changed;
        nx = m_x;
        ny = m_y;
        if (m_pend[4]) begin
            nx = NX / 2;
            ny = NY / 2;
        end else begin
            if (m_pend[2] && !m_pend[3]) nx = (m_x + NX - 1) % NX;
            if (m_pend[3] && !m_pend[2]) nx = (m_x + 1) % NX;
            if (m_pend[0] && !m_pend[1]) ny = (m_y + NY - 1) % NY;
            if (m_pend[1] && !m_pend[0]) ny = (m_y + 1) % NY;
        end
        changed = (nx != m_x) || (ny != m_y);
        m_x = nx;
        m_y = ny;
        for (int i = 0; i < 5; i++) m_pend[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_held[i]) begin
                m_ticks[i]++;
                if (m_ticks[i] >= DLY && ((m_ticks[i] - DLY) % RATE) == 0) m_pend[i] = 1'b1;
            end
        end
        return changed;
    endfunction

    task automatic drive_btns(input logic [4:0] l);
        bus.iBtnUp     = l[0];
        bus.iBtnDown   = l[1];
        bus.iBtnLeft   = l[2];
        bus.iBtnRight  = l[3];
        bus.iBtnCenter = l[4];
    endtask

    // One frame: level change at cycle 10, short press 10..20, glitch 30..32 or reset 30..32,
    // vsync low from cycle 60; model commit applied at frame end.
    task automatic run_frame(input logic [4:0] lvls, input logic [4:0] short_m,
                             input logic [4:0] glitch_m, input bit do_reset);
        int strobes;
        logic [3:0] px, py;
        bit changed, moved;
        strobes = 0;
        px = bus.oMarkedBlockPosX;
        py = bus.oMarkedBlockPosY;
        for (int c = 0; c < FRAME_LEN; c++) begin
            @(posedge Clock);
            #1;
            if (bus.oMoveStrobe === 1'b1) strobes++;
            moved = (bus.oMarkedBlockPosX !== px) || (bus.oMarkedBlockPosY !== py);
            if (!(do_reset && c >= 30 && c <= 32)) begin
                vectors++;
                if (moved !== (bus.oMoveStrobe === 1'b1)) begin
                    miscompares++;
                    $display("FAIL strobe_align: cycle %0d strobe=%b moved=%b", c, bus.oMoveStrobe, moved);
                end
            end
            px = bus.oMarkedBlockPosX;
            py = bus.oMarkedBlockPosY;
            if (do_reset && c == 31) begin
                vectors++;
                if (bus.oMarkedBlockPosX !== 4'd0 || bus.oMarkedBlockPosY !== 4'd0 || bus.oMoveStrobe !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_clear: got (%0d,%0d) strobe=%b expected (0,0) strobe=0",
                             bus.oMarkedBlockPosX, bus.oMarkedBlockPosY, bus.oMoveStrobe);
                end
            end
            if (c == 40) begin
                vectors++;
                if (bus.oMarkedBlockPosX !== 4'(m_x) || bus.oMarkedBlockPosY !== 4'(m_y)) begin
                    miscompares++;
                    $display("FAIL mid_frame_hold: got (%0d,%0d) expected (%0d,%0d)",
                             bus.oMarkedBlockPosX, bus.oMarkedBlockPosY, m_x, m_y);
                end
            end
            if (c == 0)  bus.iVGAVerticalSync = 1'b1;
            if (c == 60) bus.iVGAVerticalSync = 1'b0;
            if (c == 10) begin
                drive_btns(lvls | short_m);
                model_set_levels(lvls | short_m);
            end
            if (c == 20 && short_m != 5'b0) begin
                drive_btns(lvls);
                model_set_levels(lvls);
            end
            if (c == 30) begin
                if (do_reset) begin
                    Reset = 1'b1;
                    model_reset();
                end else begin
                    drive_btns(lvls | glitch_m);
                end
            end
            if (c == 32) begin
                if (do_reset) begin
                    Reset = 1'b0;
                    model_set_levels(lvls);
                end else begin
                    drive_btns(lvls);
                end
            end
        end
        changed = model_tick();
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'(m_x) || bus.oMarkedBlockPosY !== 4'(m_y)) begin
            miscompares++;
            $display("FAIL pos_commit: got (%0d,%0d) expected (%0d,%0d)",
                     bus.oMarkedBlockPosX, bus.oMarkedBlockPosY, m_x, m_y);
        end
        vectors++;
        if (strobes != (changed ? 1 : 0)) begin
            miscompares++;
            $display("FAIL strobe_count: got %0d expected %0d", strobes, changed ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.iVGAVerticalSync = 1'b1;
        drive_btns(5'b0);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock);
            #1;
            vectors++;
            if (bus.oMarkedBlockPosX !== 4'd0 || bus.oMarkedBlockPosY !== 4'd0 || bus.oMoveStrobe !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: got (%0d,%0d) strobe=%b expected (0,0) strobe=0",
                         bus.oMarkedBlockPosX, bus.oMarkedBlockPosY, bus.oMoveStrobe);
            end
        end
        Reset = 1'b0;
        for (int f = 0; f < 5; f++) run_frame(5'b0, 5'b0, 5'b0, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd0 || bus.oMarkedBlockPosY !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_frames: got (%0d,%0d) expected (0,0)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
    endtask

    task automatic test_glitch_press();
        run_frame(5'b0, 5'b0, 5'b01000, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd0 || bus.oMarkedBlockPosY !== 4'd0) begin
            miscompares++;
            $display("FAIL glitch_ignored: got (%0d,%0d) expected (0,0)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
        run_frame(5'b0, 5'b01000, 5'b0, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd1 || bus.oMarkedBlockPosY !== 4'd0) begin
            miscompares++;
            $display("FAIL short_right: got (%0d,%0d) expected (1,0)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
        run_frame(5'b0, 5'b00100, 5'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [4:0] presses [4];
        int ex [4];
        int ey [4];
        presses = '{5'b00100, 5'b00001, 5'b01000, 5'b00010};
        ex = '{9, 9, 0, 0};
        ey = '{0, 7, 7, 0};
        for (int i = 0; i < 4; i++) begin
            run_frame(5'b0, presses[i], 5'b0, 1'b0);
            vectors++;
            if (bus.oMarkedBlockPosX !== 4'(ex[i]) || bus.oMarkedBlockPosY !== 4'(ey[i])) begin
                miscompares++;
                $display("FAIL wrap_%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                         bus.oMarkedBlockPosX, bus.oMarkedBlockPosY, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int ex [10];
        ex = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 4};
        for (int f = 0; f < 10; f++) begin
            run_frame((f < 8) ? 5'b01000 : 5'b0, 5'b0, 5'b0, 1'b0);
            vectors++;
            if (bus.oMarkedBlockPosX !== 4'(ex[f]) || bus.oMarkedBlockPosY !== 4'd0) begin
                miscompares++;
                $display("FAIL auto_repeat_f%0d: got (%0d,%0d) expected (%0d,0)", f,
                         bus.oMarkedBlockPosX, bus.oMarkedBlockPosY, ex[f]);
            end
        end
    endtask

    task automatic test_combos();
        run_frame(5'b0, 5'b01110, 5'b0, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd4 || bus.oMarkedBlockPosY !== 4'd1) begin
            miscompares++;
            $display("FAIL lr_cancel_down: got (%0d,%0d) expected (4,1)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
        run_frame(5'b0, 5'b11000, 5'b0, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd5 || bus.oMarkedBlockPosY !== 4'd4) begin
            miscompares++;
            $display("FAIL centre_wins: got (%0d,%0d) expected (5,4)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
        run_frame(5'b0, 5'b10000, 5'b0, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd5 || bus.oMarkedBlockPosY !== 4'd4) begin
            miscompares++;
            $display("FAIL centre_again: got (%0d,%0d) expected (5,4)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
    endtask

    task automatic test_reset_mid_repeat();
        for (int f = 0; f < 5; f++) run_frame(5'b00010, 5'b0, 5'b0, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd5 || bus.oMarkedBlockPosY !== 4'd6) begin
            miscompares++;
            $display("FAIL down_repeat: got (%0d,%0d) expected (5,6)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
        run_frame(5'b00010, 5'b0, 5'b0, 1'b1);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd0 || bus.oMarkedBlockPosY !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_fresh_press: got (%0d,%0d) expected (0,1)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
        run_frame(5'b0, 5'b0, 5'b0, 1'b0);
        vectors++;
        if (bus.oMarkedBlockPosX !== 4'd0 || bus.oMarkedBlockPosY !== 4'd1) begin
            miscompares++;
            $display("FAIL release_after_reset: got (%0d,%0d) expected (0,1)", bus.oMarkedBlockPosX, bus.oMarkedBlockPosY);
        end
    endtask

    task automatic test_random();
        logic [4:0] lvls, short_m, glitch_m;
        bit do_reset;
        lvls = 5'b0;
        for (int f = 0; f < 60; f++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(3) == 0) lvls[b] = ~lvls[b];
            end
            short_m  = ($urandom_range(2) == 0) ? (5'($urandom) & ~lvls) : 5'b0;
            do_reset = ($urandom_range(19) == 0);
            glitch_m = (!do_reset && $urandom_range(3) == 0) ? (5'($urandom) & ~lvls & ~short_m) : 5'b0;
            run_frame(lvls, short_m, glitch_m, do_reset);
        end
        run_frame(5'b0, 5'b0, 5'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_glitch_press();
        test_wrap();
        test_auto_repeat();
        test_combos();
        test_reset_mid_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
